branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_if.sv | 30 +++
 rtl/branch_sequencer.sv | 151 +++++++++++++++
 tb/tb_branch_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Handshake and status bundle between the instruction front end and branch_sequencer.
// The master drives instructions, ALU flags and stall. The slave (the sequencer) drives pc and status.
interface branch_sequencer_if;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] target;
  logic        alu_busy;
  logic        flags_valid;
  logic        sign;
  logic        carry;
  logic        zero;
  logic        stall;
  logic [31:0] pc;
  logic        accept;
  logic        flush;
  logic        taken;
  logic        halted;
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  modport master (
    output instr_valid, opcode, target, alu_busy, flags_valid, sign, carry, zero, stall,
    input  pc, accept, flush, taken, halted, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  instr_valid, opcode, target, alu_busy, flags_valid, sign, carry, zero, stall,
    output pc, accept, flush, taken, halted, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// Branch sequencer: PC update, conditional branch resolution on ALU flags, redirect and halt.
// Defining BRANCH_SEQ_STATS_EN enables saturating taken / not-taken counters.
module branch_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StRun, StWaitFlag, StRedirect, StHalt} state_e;

  localparam logic [5:0] OpBr   = 6'b001100;
  localparam logic [5:0] OpBz   = 6'b001111;
  localparam logic [5:0] OpBmi  = 6'b001101;
  localparam logic [5:0] OpBpl  = 6'b001010;
  localparam logic [5:0] OpHalt = 6'b111111;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [5:0]  op_q;
  logic [2:0]  flags_q;  // {s, c, z}
  logic        flush_q;
  logic        taken_q;

  logic [2:0]  eval_flags;
  logic [5:0]  eval_op;
  logic        eval_hit;

  function automatic logic is_cond(input logic [5:0] op);
    return (op == OpBz) || (op == OpBmi) || (op == OpBpl);
  endfunction

  function automatic logic cond_true(input logic [5:0] op, input logic [2:0] f);
    logic s, c, z;
    {s, c, z} = f;
    case (op)
      OpBz:    return !s && z;
      OpBmi:   return s && c;
      OpBpl:   return !s && !c;
      default: return 1'b0;
    endcase
  endfunction

  // Flags arriving in the evaluating cycle bypass the flag register.
  always_comb begin
    eval_flags = bus.flags_valid ? {bus.sign, bus.carry, bus.zero} : flags_q;
    eval_op    = (state_q == StWaitFlag) ? op_q : bus.opcode;
    eval_hit   = cond_true(eval_op, eval_flags);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= 32'h0;
      target_q <= 32'h0;
      op_q     <= 6'h0;
      flags_q  <= 3'b000;
      flush_q  <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      if (bus.flags_valid) flags_q <= {bus.sign, bus.carry, bus.zero};
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      if (!bus.stall) begin
        unique case (state_q)
          StRun: begin
            if (bus.instr_valid) begin
              if (bus.opcode == OpBr) begin
                target_q <= bus.target;
                state_q  <= StRedirect;
              end else if (bus.opcode == OpHalt) begin
                state_q <= StHalt;
              end else if (is_cond(bus.opcode)) begin
                if (bus.alu_busy) begin
                  op_q     <= bus.opcode;
                  target_q <= bus.target;
                  state_q  <= StWaitFlag;
                end else if (eval_hit) begin
                  target_q <= bus.target;
                  state_q  <= StRedirect;
                end else begin
                  pc_q <= pc_q + 32'd4;
                end
              end else begin
                pc_q <= pc_q + 32'd4;
              end
            end
          end
          StWaitFlag: begin
            if (!bus.alu_busy) begin
              if (eval_hit) begin
                state_q <= StRedirect;
              end else begin
                pc_q    <= pc_q + 32'd4;
                state_q <= StRun;
              end
            end
          end
          StRedirect: begin
            pc_q    <= target_q;
            flush_q <= 1'b1;
            taken_q <= 1'b1;
            state_q <= StRun;
          end
          StHalt: state_q <= StHalt;
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign bus.pc     = pc_q;
  assign bus.accept = rst_n && !bus.stall && bus.instr_valid && (state_q == StRun);
  assign bus.flush  = flush_q;
  assign bus.taken  = taken_q;
  assign bus.halted = (state_q == StHalt);

`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] nottaken_cnt_q;
  logic        taken_evt;
  logic        nottaken_evt;

  // A branch counts as taken when its redirect actually commits.
  always_comb begin
    taken_evt    = !bus.stall && (state_q == StRedirect);
    nottaken_evt = !bus.stall && !bus.alu_busy && !eval_hit &&
                   ((state_q == StWaitFlag) ||
                    ((state_q == StRun) && bus.instr_valid && is_cond(bus.opcode)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_q    <= 16'h0;
      nottaken_cnt_q <= 16'h0;
    end else begin
      if (taken_evt && (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 16'd1;
      if (nottaken_evt && (nottaken_cnt_q != 16'hFFFF)) begin
        nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;
`else
  assign bus.taken_cnt    = 16'h0;
  assign bus.nottaken_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vectors, a behavioural reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_branch_sequencer;

  localparam bit [5:0] OpNop  = 6'b000000;
  localparam bit [5:0] OpBr   = 6'b001100;
  localparam bit [5:0] OpBz   = 6'b001111;
  localparam bit [5:0] OpBmi  = 6'b001101;
  localparam bit [5:0] OpBpl  = 6'b001010;
  localparam bit [5:0] OpHalt = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  branch_sequencer_if bus ();

  branch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what the sequencer must look like after each edge.
  bit [31:0] m_pc, m_tgt;
  bit [5:0]  m_op;
  bit [2:0]  m_fl;
  bit        m_wait, m_redir, m_halt, m_flush, m_taken;
  int        m_tc, m_nc;

  function automatic bit br_taken(input bit [5:0] op, input bit s, input bit c, input bit z);
    if (op == OpBz)  return !s && z;
    if (op == OpBmi) return s && c;
    if (op == OpBpl) return !s && !c;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit s, c, z, resolve;
    bit [5:0]  op;
    bit [31:0] tg;
    resolve = 1'b0;
    op = 6'h0;
    tg = 32'h0;
    if (!rst_n) begin
      m_pc = 0; m_fl = 0; m_wait = 0; m_redir = 0; m_halt = 0;
      m_flush = 0; m_taken = 0; m_tc = 0; m_nc = 0;
    end else begin
      m_flush = 0;
      m_taken = 0;
      {s, c, z} = bus.flags_valid ? {bus.sign, bus.carry, bus.zero} : m_fl;
      if (!bus.stall && !m_halt) begin
        if (m_redir) begin
          m_pc = m_tgt; m_redir = 0; m_flush = 1; m_taken = 1;
          if (m_tc < 65535) m_tc++;
        end else if (m_wait) begin
          if (!bus.alu_busy) begin resolve = 1; op = m_op; tg = m_tgt; m_wait = 0; end
        end else if (bus.instr_valid) begin
          op = bus.opcode;
          tg = bus.target;
          if (op == OpBr) begin
            m_redir = 1; m_tgt = tg;
          end else if (op == OpHalt) begin
            m_halt = 1;
          end else if (op == OpBz || op == OpBmi || op == OpBpl) begin
            if (bus.alu_busy) begin m_wait = 1; m_op = op; m_tgt = tg; end
            else resolve = 1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
        if (resolve) begin
          if (br_taken(op, s, c, z)) begin
            m_redir = 1; m_tgt = tg;
          end else begin
            m_pc = m_pc + 32'd4;
            if (m_nc < 65535) m_nc++;
          end
        end
      end
      if (bus.flags_valid) m_fl = {bus.sign, bus.carry, bus.zero};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model pc", bus.pc, m_pc);
      chk("model accept", {31'b0, bus.accept},
          {31'b0, rst_n && !bus.stall && bus.instr_valid && !m_halt && !m_redir && !m_wait});
      chk("model flush", {31'b0, bus.flush}, {31'b0, m_flush});
      chk("model taken", {31'b0, bus.taken}, {31'b0, m_taken});
      chk("model halted", {31'b0, bus.halted}, {31'b0, m_halt});
`ifdef BRANCH_SEQ_STATS_EN
      chk("model taken_cnt", {16'b0, bus.taken_cnt}, m_tc);
      chk("model nottaken_cnt", {16'b0, bus.nottaken_cnt}, m_nc);
`else
      chk("taken_cnt tied", {16'b0, bus.taken_cnt}, 32'h0);
      chk("nottaken_cnt tied", {16'b0, bus.nottaken_cnt}, 32'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit [5:0] op, input bit [31:0] tg, input bit busy);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.target      = tg;
    bus.alu_busy    = busy;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.opcode      = OpNop;
  endtask

  task automatic set_flags(input bit v, input bit s, input bit c, input bit z);
    bus.flags_valid = v;
    bus.sign        = s;
    bus.carry       = c;
    bus.zero        = z;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.target = 32'h0;
    bus.alu_busy = 1'b0;
    bus.stall = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset pc", bus.pc, 32'h0);
    chk("reset halted", {31'b0, bus.halted}, 32'h0);
    chk("reset flush", {31'b0, bus.flush}, 32'h0);

    // Three sequential instructions
    rst_n = 1'b1;
    issue(OpNop, 32'h0, 1'b0);
    #1 chk("seq accept", {31'b0, bus.accept}, 32'h1);
    chk("seq pc0", bus.pc, 32'h0);
    tick(); chk("seq pc1", bus.pc, 32'h4);
    tick(); chk("seq pc2", bus.pc, 32'h8);
    tick(); chk("seq pc3", bus.pc, 32'hC);

    // Unconditional branch
    issue(OpBr, 32'h100, 1'b0);
    tick(); idle();
    chk("br hold pc", bus.pc, 32'hC);
    chk("br no flush yet", {31'b0, bus.flush}, 32'h0);
    tick();
    chk("br pc", bus.pc, 32'h100);
    chk("br flush", {31'b0, bus.flush}, 32'h1);
    chk("br taken", {31'b0, bus.taken}, 32'h1);
    tick();
    chk("br flush one cycle", {31'b0, bus.flush}, 32'h0);

    // BZ waiting on a busy ALU
    issue(OpBz, 32'h200, 1'b1);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      chk("bz wait pc", bus.pc, 32'h100);
      tick();
    end
    chk("bz wait pc", bus.pc, 32'h100);
    bus.alu_busy = 1'b0;
    set_flags(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bz resolve pc", bus.pc, 32'h100);
    tick();
    chk("bz redirect pc", bus.pc, 32'h200);
    chk("bz flush", {31'b0, bus.flush}, 32'h1);

    // BMI on registered s=1 c=0: not taken
    set_flags(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    issue(OpBmi, 32'h300, 1'b0);
    tick(); idle();
    chk("bmi nt pc", bus.pc, 32'h204);
    chk("bmi nt flush", {31'b0, bus.flush}, 32'h0);
    tick();
    chk("bmi nt no redirect", bus.pc, 32'h204);

    // BPL on registered s=0 c=0: taken
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    issue(OpBpl, 32'h400, 1'b0);
    tick(); idle();
    tick();
    chk("bpl pc", bus.pc, 32'h400);
    chk("bpl taken", {31'b0, bus.taken}, 32'h1);

    // BMI with bypassed flags s=1 c=1 overriding registered s=0 c=0
    issue(OpBmi, 32'h700, 1'b0);
    set_flags(1'b1, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bypass pc", bus.pc, 32'h700);

    // Stall held over the redirect cycle
    issue(OpBr, 32'h500, 1'b0);
    tick(); idle();
    bus.stall = 1'b1;
    tick();
    chk("stall pc", bus.pc, 32'h700);
    chk("stall flush", {31'b0, bus.flush}, 32'h0);
    tick();
    chk("stall pc 2", bus.pc, 32'h700);
    bus.stall = 1'b0;
    tick();
    chk("unstall pc", bus.pc, 32'h500);
    chk("unstall flush", {31'b0, bus.flush}, 32'h1);

    // Reset while waiting for flags drops the branch
    issue(OpBz, 32'h600, 1'b1);
    tick(); idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("wait reset pc", bus.pc, 32'h0);
    bus.alu_busy = 1'b0;
    set_flags(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("no redirect pc", bus.pc, 32'h0);
    chk("no redirect flush", {31'b0, bus.flush}, 32'h0);

    // HALT ignores later instructions
    issue(OpHalt, 32'h0, 1'b0);
    tick();
    issue(OpNop, 32'h0, 1'b0);
    #1 chk("halt accept", {31'b0, bus.accept}, 32'h0);
    chk("halted", {31'b0, bus.halted}, 32'h1);
    tick(); tick();
    chk("halt pc", bus.pc, 32'h0);
    chk("still halted", {31'b0, bus.halted}, 32'h1);
    idle();

`ifdef BRANCH_SEQ_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      issue(OpBr, 32'h40, 1'b0);
      tick(); idle();
      tick();
    end
    chk("taken_cnt saturated", {16'b0, bus.taken_cnt}, 32'hFFFF);
`else
    chk("taken_cnt zero", {16'b0, bus.taken_cnt}, 32'h0);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
